// File: rtl/edge_detection_pkg.sv
// Shared types and defaults for the edge-detection pixel path.
// Used by the colorspace converter, line buffer and edge kernel.
package edge_detection_pkg;

    localparam int PIX_W_DEF    = 8;
    localparam int H_ACTIVE_DEF = 640;
    localparam int COL_W_DEF    = $clog2(H_ACTIVE_DEF);

    typedef logic [PIX_W_DEF-1:0] pix_t;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic de;
    } sync_t;

    function automatic int col_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single line store: 1 write port, 1 synchronous read port.
// Same-address read and write return the old contents.
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // array write; contents survive reset
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // registered read, holds when not enabled
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_buffer.sv
// Two-line buffer producing 3-pixel columns, 2-cycle latency.
// Option: LINE_BUFFER_BORDER_ZERO_EN zeroes TOP/MID above frame.
module line_buffer
    import edge_detection_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int PIX_W    = PIX_W_DEF
) (
    input  logic             I_PCLK,
    input  logic             I_RST,
    input  logic [PIX_W-1:0] I_GRAY,
    input  logic             I_VSYNC,
    input  logic             I_HSYNC,
    input  logic             I_DE,
    output logic [PIX_W-1:0] O_COL_TOP,
    output logic [PIX_W-1:0] O_COL_MID,
    output logic [PIX_W-1:0] O_COL_BOT,
    output logic             O_VSYNC,
    output logic             O_HSYNC,
    output logic             O_DE,
    output logic             O_LINE_VALID,
    output logic             O_OVF
);

    localparam int COL_W = col_w(H_ACTIVE);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);

    logic [COL_W-1:0] col_q;
    logic             full_q;
    logic [1:0]       lines_q;

    sync_t            s1_sync;
    logic [PIX_W-1:0] s1_pix;
    logic [COL_W-1:0] s1_col;
    logic             s1_ovf;
    logic             s1_full2;
    logic             s1_vsr;

    logic             s2_we;
    logic [COL_W-1:0] s2_col;

    logic [PIX_W-1:0] rd0;
    logic [PIX_W-1:0] rd1;

    logic vs_rise;
    logic line_end;
    logic ovf_now;
    logic s1_acc;

    assign vs_rise  = I_VSYNC & ~s1_sync.vsync;
    assign line_end = s1_sync.de & ~I_DE;
    assign ovf_now  = I_DE & full_q;
    assign s1_acc   = s1_sync.de & ~s1_ovf;

    // column counter; holds on the last column once the line is full
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            col_q  <= '0;
            full_q <= 1'b0;
        end else if (!I_DE) begin
            col_q  <= '0;
            full_q <= 1'b0;
        end else if (col_q == COL_LAST) begin
            full_q <= 1'b1;
        end else begin
            col_q <= col_q + 1'b1;
        end
    end

    // stored-line count, frame start clears even on a line end
    always_ff @(posedge I_PCLK) begin
        if (I_RST)
            lines_q <= '0;
        else if (vs_rise)
            lines_q <= '0;
        else if (line_end && lines_q != 2'd2)
            lines_q <= lines_q + 1'b1;
    end

    // stage 1: capture pixel, syncs, address and frame status
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            s1_sync  <= '0;
            s1_pix   <= '0;
            s1_col   <= '0;
            s1_ovf   <= 1'b0;
            s1_full2 <= 1'b0;
            s1_vsr   <= 1'b0;
        end else begin
            s1_sync  <= '{vsync: I_VSYNC, hsync: I_HSYNC, de: I_DE};
            s1_pix   <= I_GRAY;
            s1_col   <= col_q;
            s1_ovf   <= ovf_now;
            s1_full2 <= (lines_q == 2'd2);
            s1_vsr   <= vs_rise;
        end
    end

    // stage 2: aligned syncs, current pixel and sticky overflow
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            O_VSYNC      <= 1'b0;
            O_HSYNC      <= 1'b0;
            O_DE         <= 1'b0;
            O_COL_BOT    <= '0;
            O_LINE_VALID <= 1'b0;
            O_OVF        <= 1'b0;
        end else begin
            O_VSYNC      <= s1_sync.vsync;
            O_HSYNC      <= s1_sync.hsync;
            O_DE         <= s1_sync.de;
            O_COL_BOT    <= s1_pix;
            O_LINE_VALID <= s1_sync.de & s1_full2;
            O_OVF        <= s1_vsr ? 1'b0 : (O_OVF | s1_ovf);
        end
    end

    // RAM1 takes the old RAM0 word one cycle after it is read out
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            s2_we  <= 1'b0;
            s2_col <= '0;
        end else begin
            s2_we  <= s1_acc;
            s2_col <= s1_col;
        end
    end

    line_ram #(
        .DEPTH (H_ACTIVE),
        .WIDTH (PIX_W),
        .AW    (COL_W)
    ) u_ram0 (
        .clk   (I_PCLK),
        .rst   (I_RST),
        .we    (s1_acc),
        .waddr (s1_col),
        .wdata (s1_pix),
        .re    (s1_acc),
        .raddr (s1_col),
        .rdata (rd0)
    );

    line_ram #(
        .DEPTH (H_ACTIVE),
        .WIDTH (PIX_W),
        .AW    (COL_W)
    ) u_ram1 (
        .clk   (I_PCLK),
        .rst   (I_RST),
        .we    (s2_we),
        .waddr (s2_col),
        .wdata (rd0),
        .re    (s1_acc),
        .raddr (s1_col),
        .rdata (rd1)
    );

`ifdef LINE_BUFFER_BORDER_ZERO_EN
    logic s1_top_z;
    logic s1_mid_z;
    logic s2_top_z;
    logic s2_mid_z;

    // border masks follow the pixel through both stages
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            s1_top_z <= 1'b0;
            s1_mid_z <= 1'b0;
            s2_top_z <= 1'b0;
            s2_mid_z <= 1'b0;
        end else begin
            s1_top_z <= (lines_q < 2'd2);
            s1_mid_z <= (lines_q == 2'd0);
            s2_top_z <= s1_top_z;
            s2_mid_z <= s1_mid_z;
        end
    end

    assign O_COL_TOP = s2_top_z ? '0 : rd1;
    assign O_COL_MID = s2_mid_z ? '0 : rd0;
`else
    assign O_COL_TOP = rd1;
    assign O_COL_MID = rd0;
`endif

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer: fill, gradient, overflow,
// frame restart, mid-line reset and sync alignment.
module tb_line_buffer;

    localparam int CST = 0;
    localparam int GRD = 1;
    localparam int XRV = 2;

    logic       I_PCLK = 1'b0;
    logic       I_RST  = 1'b1;
    logic [7:0] I_GRAY = '0;
    logic       I_VSYNC = 1'b0;
    logic       I_HSYNC = 1'b0;
    logic       I_DE    = 1'b0;
    logic [7:0] O_COL_TOP;
    logic [7:0] O_COL_MID;
    logic [7:0] O_COL_BOT;
    logic       O_VSYNC;
    logic       O_HSYNC;
    logic       O_DE;
    logic       O_LINE_VALID;
    logic       O_OVF;

    int checks   = 0;
    int failures = 0;

    bit         e_ck, e_ct, e_cm;
    logic [7:0] e_top, e_mid;
    logic       e_val;
    logic       e_ovf = 1'b0;
    string      e_nm = "init";

    bit         p_sv = 0, p_ck = 0, p_ct = 0, p_cm = 0;
    logic [7:0] p_top, p_mid, p_bot;
    logic       p_val, p_ovf;
    logic [2:0] p_sync;
    string      p_nm = "init";

    line_buffer #(
        .H_ACTIVE (640),
        .PIX_W    (8)
    ) dut (
        .I_PCLK       (I_PCLK),
        .I_RST        (I_RST),
        .I_GRAY       (I_GRAY),
        .I_VSYNC      (I_VSYNC),
        .I_HSYNC      (I_HSYNC),
        .I_DE         (I_DE),
        .O_COL_TOP    (O_COL_TOP),
        .O_COL_MID    (O_COL_MID),
        .O_COL_BOT    (O_COL_BOT),
        .O_VSYNC      (O_VSYNC),
        .O_HSYNC      (O_HSYNC),
        .O_DE         (O_DE),
        .O_LINE_VALID (O_LINE_VALID),
        .O_OVF        (O_OVF)
    );

    always #5 I_PCLK = ~I_PCLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pv(input int m,
                                      input logic [7:0] v,
                                      input int c);
        int cc;
        logic [7:0] lo;
        cc = (c > 639) ? 639 : c;
        lo = 8'(cc);
        case (m)
            GRD:     return lo;
            XRV:     return lo ^ v;
            default: return v;
        endcase
    endfunction

    // one input cycle; outputs now reflect the previous cycle's input
    task automatic px(input logic de, input logic [7:0] g,
                      input logic vs, input logic hs);
        I_DE = de; I_GRAY = g; I_VSYNC = vs; I_HSYNC = hs;
        @(posedge I_PCLK);
        #1;
        if (p_sv && !I_RST)
            chk({p_nm, ".sync"}, {O_VSYNC, O_HSYNC, O_DE}, p_sync);
        if (p_ck && !I_RST) begin
            chk({p_nm, ".bot"}, O_COL_BOT, p_bot);
            chk({p_nm, ".valid"}, O_LINE_VALID, p_val);
            chk({p_nm, ".ovf"}, O_OVF, p_ovf);
            if (p_ct) chk({p_nm, ".top"}, O_COL_TOP, p_top);
            if (p_cm) chk({p_nm, ".mid"}, O_COL_MID, p_mid);
        end
        p_sv = !I_RST;
        p_ck = e_ck && de && !I_RST;
        p_ct = e_ct; p_cm = e_cm;
        p_top = e_top; p_mid = e_mid; p_bot = g;
        p_val = e_val; p_ovf = e_ovf;
        p_sync = {vs, hs, de};
        p_nm = e_nm;
    endtask

    task automatic line(input string nm, input int len,
                        input int pm, input logic [7:0] pvv,
                        input int tm, input logic [7:0] tv,
                        input bit ct,
                        input int mm, input logic [7:0] mv,
                        input bit cm,
                        input logic val, input logic gvs);
        logic [7:0] g;
        e_nm = nm;
        for (int c = 0; c < len; c++) begin
            e_ck = (pm == GRD) || c < 2 || c == 319 ||
                   c == 639 || c == 640 || c == len - 1;
            e_ct = ct; e_cm = cm;
            e_top = pv(tm, tv, c);
            e_mid = pv(mm, mv, c);
            e_val = val;
            if (c >= 640) e_ovf = 1'b1;
            g = 8'(c);
            if (pm == CST) g = pvv;
            else if (pm == XRV) g = g ^ pvv;
            px(1'b1, g, 1'b0, 1'b0);
        end
        px(1'b0, 8'h00, gvs, 1'b0);
    endtask

    task automatic vpulse();
        px(1'b0, 8'h00, 1'b0, 1'b1);
        px(1'b0, 8'h00, 1'b1, 1'b0);
        px(1'b0, 8'h00, 1'b1, 1'b0);
        px(1'b0, 8'h00, 1'b0, 1'b0);
        e_ovf = 1'b0;
    endtask

    initial begin
        logic [2:0] r;
        logic [7:0] t1, t2, t3, m1;

        I_RST = 1'b1;
        px(1'b1, 8'h55, 1'b0, 1'b1);
        px(1'b1, 8'h55, 1'b0, 1'b1);
        chk("rst_out", {O_COL_TOP, O_COL_MID, O_COL_BOT, O_VSYNC,
                        O_HSYNC, O_DE, O_LINE_VALID, O_OVF}, 0);
        I_RST = 1'b0;
        px(1'b0, 8'h00, 1'b0, 1'b0);
        vpulse();

        line("L1", 640, CST, 8'h10, CST, 0, 0, CST, 0, 0, 0, 0);
        line("L2", 640, CST, 8'h20, CST, 0, 0,
             CST, 8'h10, 1, 0, 0);
        line("L3", 640, CST, 8'h30, CST, 8'h10, 1,
             CST, 8'h20, 1, 1, 0);
        line("L4", 640, GRD, 0, CST, 8'h20, 1, CST, 8'h30, 1, 1, 0);
        line("L5", 640, GRD, 0, CST, 8'h30, 1, GRD, 0, 1, 1, 0);
        line("L6", 640, GRD, 0, GRD, 0, 1, GRD, 0, 1, 1, 0);
        line("L7ovf", 650, XRV, 8'h55, GRD, 0, 1, GRD, 0, 1, 1, 0);
        line("L8", 640, CST, 8'hB0, GRD, 0, 1,
             XRV, 8'h55, 1, 1, 0);
        vpulse();

`ifdef LINE_BUFFER_BORDER_ZERO_EN
        line("F2A", 640, CST, 8'hC0, CST, 0, 1, CST, 0, 1, 0, 0);
        t1 = 8'h00;
`else
        line("F2A", 640, CST, 8'hC0, XRV, 8'h55, 1,
             CST, 8'hB0, 1, 0, 0);
        t1 = 8'hB0;
`endif
        line("F2B", 640, CST, 8'hD0, CST, t1, 1,
             CST, 8'hC0, 1, 0, 0);
        line("F2C", 640, CST, 8'hE0, CST, 8'hC0, 1,
             CST, 8'hD0, 1, 1, 1);
        px(1'b0, 8'h00, 1'b0, 1'b0);

`ifdef LINE_BUFFER_BORDER_ZERO_EN
        t2 = 8'h00; m1 = 8'h00; t3 = 8'h00;
`else
        t2 = 8'hD0; m1 = 8'hE0; t3 = 8'hE0;
`endif
        line("F3A", 640, CST, 8'h01, CST, t2, 1,
             CST, m1, 1, 0, 0);
        line("F3B", 640, CST, 8'h02, CST, t3, 1,
             CST, 8'h01, 1, 0, 0);
        line("F3C", 640, CST, 8'h03, CST, 8'h01, 1,
             CST, 8'h02, 1, 1, 0);

        e_nm = "M"; e_ck = 0;
        for (int c = 0; c < 300; c++)
            px(1'b1, 8'h44, 1'b0, 1'b0);
        I_RST = 1'b1;
        px(1'b1, 8'h44, 1'b0, 1'b0);
        chk("rst_mid", {O_COL_TOP, O_COL_MID, O_COL_BOT, O_VSYNC,
                        O_HSYNC, O_DE, O_LINE_VALID, O_OVF}, 0);
        I_RST = 1'b0;
        line("R1", 640, CST, 8'h11, CST, 0, 0, CST, 0, 0, 0, 0);
        line("R2", 640, CST, 8'h22, CST, 0, 0,
             CST, 8'h11, 1, 0, 0);
        line("R3", 640, CST, 8'h33, CST, 8'h11, 1,
             CST, 8'h22, 1, 1, 0);

        e_nm = "rnd"; e_ck = 0;
        for (int i = 0; i < 300; i++) begin
            r = 3'($urandom);
            px(r[0], 8'($urandom), r[1], r[2]);
        end
        px(1'b0, 8'h00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
